dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port round-robin arbiter in front of the single-ported DataMem.
//   Port 0 is the CPU MEM stage; port 1 is the loader/DMA port.
//   Issues at most one access per cycle and tracks the one-cycle read latency.
//   Routes returned read data to the port that issued the read.
//   Range-checks word addresses against DEPTH and never sends out-of-range accesses to memory.
// PARAMETERS
//   ADDR_W  32   requester/memory address width (word index)
//   DATA_W  32   data width
//   DEPTH   256  number of valid memory words; addr >= DEPTH is an error
// PORTS
//   clk          in   1       rising-edge clock, shared with DataMem
//   rst_n        in   1       asynchronous active-low reset
//   req0/req1    in   1       access request, held until gnt
//   we0/we1      in   1       1=write, 0=read; valid with req
//   lock0/lock1  in   1       keep priority after this grant (burst)
//   addr0/addr1  in   ADDR_W  word address; valid with req
//   wdata0/1     in   DATA_W  write data; valid with req&we
//   gnt0/gnt1    out  1       combinational; access accepted this cycle
//   rvalid0/1    out  1       registered; read data/error valid this cycle
//   rdata0/1     out  DATA_W  read data; valid with rvalid, else 0
//   err0/err1    out  1       registered; out-of-range access flag, 1 cycle after gnt
//   mem_read     out  1       to DataMem read
//   mem_write    out  1       to DataMem write
//   mem_addr     out  ADDR_W  to DataMem address
//   mem_wdata    out  DATA_W  to DataMem write_data
//   mem_rdata    in   DATA_W  from DataMem read_data (valid 1 cycle after mem_read)
// BEHAVIOUR
// - Reset (rst_n=0, async): rvalid*, err*, pending regs = 0; last_winner = 1 (port 0 wins first); lock_owner = none.
//   gnt*, mem_read, mem_write = 0 while rst_n=0.
// - Arbitration (combinational each cycle):
//   - If lock_owner=k and reqk=1, grant k.
//   - Else if exactly one req, grant it.
//   - Else if both req, grant the port != last_winner.
//   - No req: no grant, mem_read = mem_write = 0.
// - On grant k:
//   - gntk = 1; at posedge, last_winner <= k.
//   - If lockk, lock_owner <= k; else lock_owner <= none.
//   - Lock is dropped when the owner deasserts req or lock.
//   - The other port's gnt is 0.
// - Issue: if addrk < DEPTH, drive mem_addr = addrk and mem_read = ~wek / mem_write = wek.
//   Drive mem_wdata = wdatak. If addrk >= DEPTH, mem_read = mem_write = 0.
// - Response (one cycle after gnt):
//   - In-range read: rvalidk = 1, rdatak = mem_rdata.
//   - In-range write: no rvalid, no err.
//   - Out-of-range read: rvalidk = 1, errk = 1, rdatak = 0.
//   - Out-of-range write: errk = 1 only; memory is unchanged.
// - Throughput: back-to-back grants allowed every cycle; responses are pipelined one per cycle, in grant order.
// - Both requesting continuously without lock: strict alternation 0,1,0,1...
// - Requesters must not change addr/we/wdata while req=1 and gnt=0.
// - Reset asserted with a read in flight: the pending rvalid is discarded; no response after reset release.
// - mem_* outputs when idle: addr/wdata = 0.
// TESTING
// - Reset release, req0 read addr 5 (mem[5]=0xA5A5_0005) -> gnt0 same cycle; rvalid0=1, rdata0=0xA5A5_0005 next cycle.
// - Both requests at once, each holding 3 reads -> grants 0,1,0,1,0,1; each rvalid routed to its own port.
// - req0 with lock0 for 4 cycles while req1 pending -> 4 consecutive gnt0; gnt1 on the cycle after lock0 drops.
// - Port 1 writes 0x1234 to addr 10, then port 0 reads addr 10 next cycle -> rdata0 = 0x1234.
// - req1 read addr 256 (DEPTH=256) -> gnt1 = 1, mem_read = 0; next cycle rvalid1 = 1, err1 = 1, rdata1 = 0.
//   Out-of-range write to addr 300 -> err1 = 1; mem unchanged.
// - Assert rst_n=0 the cycle after a granted read -> rvalid0 stays 0; first grant after release goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters sharing the single-ported DataMem.
// Range-checks word addresses and routes one-cycle-latency read data back.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P0,
        OWN_P1
    } own_e;

    own_e        lock_q, lock_d;
    logic        last_q, last_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;

    logic              any_gnt;
    logic              sel;
    logic              s_we;
    logic              s_lock;
    logic              s_inr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;

    // Lock holder first, then a lone requester, then the port that lost last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (lock_q == OWN_P0 && req0) begin
                gnt0 = 1'b1;
            end else if (lock_q == OWN_P1 && req1) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign sel     = gnt1;
    assign s_we    = sel ? we1 : we0;
    assign s_lock  = sel ? lock1 : lock0;
    assign s_addr  = sel ? addr1 : addr0;
    assign s_wdata = sel ? wdata1 : wdata0;
    assign s_inr   = s_addr < ADDR_W'(DEPTH);

    assign mem_read  = any_gnt & s_inr & ~s_we;
    assign mem_write = any_gnt & s_inr & s_we;
    assign mem_addr  = any_gnt ? s_addr : '0;
    assign mem_wdata = any_gnt ? s_wdata : '0;

    always_comb begin
        rvalid_d = {gnt1 & ~we1, gnt0 & ~we0};
        err_d    = {gnt1 & ~s_inr, gnt0 & ~s_inr};
        last_d   = any_gnt ? sel : last_q;
        lock_d   = OWN_NONE;
        if (any_gnt && s_lock) begin
            lock_d = sel ? OWN_P1 : OWN_P0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= OWN_NONE;
            last_q   <= 1'b1;
            rvalid_q <= '0;
            err_q    <= '0;
        end else begin
            lock_q   <= lock_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Errored reads return zero instead of whatever DataMem holds on its bus.
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata0  = (rvalid_q[0] & ~err_q[0]) ? mem_rdata : '0;
    assign rdata1  = (rvalid_q[1] & ~err_q[1]) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with an in-bench DataMem and a
// rule-level model checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        preload;
    logic [31:0] dmem    [0:255];
    logic [31:0] ref_mem [0:255];

    int tests;
    int fails;

    int          last_w;
    int          lock_own;
    int          last_g;
    logic [1:0]  exp_rv;
    logic [1:0]  exp_err;
    logic [31:0] exp_rd [2];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'hA5A5_0000 | i;
        end else begin
            if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;
            if (mem_read) mem_rdata <= dmem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int g;
        logic [31:0] a, d;
        logic w, lk, inr;
        if (!rst_n) begin
            exp_rv = '0;
            exp_err = '0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end
        chk("rvalid0", rvalid0, exp_rv[0]);
        chk("rvalid1", rvalid1, exp_rv[1]);
        chk("err0", err0, exp_err[0]);
        chk("err1", err1, exp_err[1]);
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        g = -1;
        if (rst_n) begin
            if (lock_own == 0 && req0) g = 0;
            else if (lock_own == 1 && req1) g = 1;
            else if (req0 && req1) g = (last_w == 0) ? 1 : 0;
            else if (req0) g = 0;
            else if (req1) g = 1;
        end
        chk("gnt0", gnt0, g == 0);
        chk("gnt1", gnt1, g == 1);
        exp_rv = '0;
        exp_err = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        if (g < 0) begin
            chk("idle mem_read", mem_read, 0);
            chk("idle mem_write", mem_write, 0);
            chk("idle mem_addr", mem_addr, 0);
            chk("idle mem_wdata", mem_wdata, 0);
            lock_own = -1;
            if (!rst_n) last_w = 1;
        end else begin
            a   = (g == 1) ? addr1 : addr0;
            d   = (g == 1) ? wdata1 : wdata0;
            w   = (g == 1) ? we1 : we0;
            lk  = (g == 1) ? lock1 : lock0;
            inr = a < 32'd256;
            chk("mem_read", mem_read, !w && inr);
            chk("mem_write", mem_write, w && inr);
            if (inr) chk("mem_addr", mem_addr, a);
            if (inr && w) chk("mem_wdata", mem_wdata, d);
            if (!w) begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = inr ? ref_mem[a[7:0]] : 32'd0;
            end
            if (!inr) exp_err[g] = 1'b1;
            if (w && inr) ref_mem[a[7:0]] = d;
            last_w = g;
            lock_own = lk ? g : -1;
        end
        last_g = g;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int k);
        logic [31:0] a;
        a = ($urandom % 8 == 0) ? 32'd256 + ($urandom % 64) : $urandom % 16;
        if (k == 0) begin
            req0 = ($urandom % 4) != 0; we0 = $urandom % 2;
            lock0 = ($urandom % 4) == 0; addr0 = a; wdata0 = $urandom;
        end else begin
            req1 = ($urandom % 4) != 0; we1 = $urandom % 2;
            lock1 = ($urandom % 4) == 0; addr1 = a; wdata1 = $urandom;
        end
    endtask

    initial begin
        int seq[$];
        int left0, left1;
        logic g0, g1;
        tests = 0; fails = 0;
        last_w = 1; lock_own = -1; last_g = -1;
        exp_rv = '0; exp_err = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A5_0000 | i;
        preload = 1'b1; rst_n = 1'b0;
        req0 = 1; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 5; addr1 = 0; wdata0 = 0; wdata1 = 0;
        @(posedge clk); #1;
        chk("reset gnt0", gnt0, 0);
        chk("reset mem_read", mem_read, 0);
        cyc();
        preload = 1'b0; req0 = 0;
        cyc();
        rst_n = 1'b1;

        req0 = 1; we0 = 0; addr0 = 5;
        #1;
        chk("rd5 gnt0", gnt0, 1);
        chk("rd5 mem_read", mem_read, 1);
        chk("rd5 mem_addr", mem_addr, 5);
        cyc();
        req0 = 0;
        #1;
        chk("rd5 rvalid0", rvalid0, 1);
        chk("rd5 rdata0", rdata0, 32'hA5A5_0005);
        cyc();

        req0 = 1; addr0 = 7;
        #1;
        chk("flight gnt0", gnt0, 1);
        cyc();
        req0 = 0; rst_n = 0;
        #1;
        chk("flight rvalid0 rst", rvalid0, 0);
        cyc();
        rst_n = 1;
        #1;
        chk("flight rvalid0 rel", rvalid0, 0);
        cyc();

        left0 = 3; left1 = 3;
        req0 = 1; we0 = 0; addr0 = 20;
        req1 = 1; we1 = 0; addr1 = 30;
        for (int c = 0; c < 10 && (left0 > 0 || left1 > 0); c++) begin
            #1;
            g0 = gnt0; g1 = gnt1;
            if (g0) seq.push_back(0);
            if (g1) seq.push_back(1);
            cyc();
            if (g0) begin left0--; addr0++; if (left0 == 0) req0 = 0; end
            if (g1) begin left1--; addr1++; if (left1 == 0) req1 = 0; end
        end
        chk("alt count", seq.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("alt order", (i < seq.size()) ? seq[i] : 99, i % 2);
        req0 = 0; req1 = 0;
        cyc();

        req0 = 1; lock0 = 1; addr0 = 40;
        req1 = 1; addr1 = 41;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lock gnt0", gnt0, 1);
            cyc();
        end
        lock0 = 0;
        #1;
        chk("lock tail gnt0", gnt0, 1);
        cyc();
        #1;
        chk("unlock gnt1", gnt1, 1);
        cyc();
        req0 = 0; req1 = 0;
        cyc();

        req1 = 1; we1 = 1; addr1 = 10; wdata1 = 32'h1234;
        #1;
        chk("wr gnt1", gnt1, 1);
        chk("wr mem_write", mem_write, 1);
        cyc();
        req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 10;
        #1;
        chk("raw gnt0", gnt0, 1);
        cyc();
        req0 = 0;
        #1;
        chk("raw rdata0", rdata0, 32'h1234);
        cyc();

        req1 = 1; we1 = 0; addr1 = 256;
        #1;
        chk("oor gnt1", gnt1, 1);
        chk("oor mem_read", mem_read, 0);
        cyc();
        we1 = 1; addr1 = 300; wdata1 = 32'hDEAD;
        #1;
        chk("oor rvalid1", rvalid1, 1);
        chk("oor err1", err1, 1);
        chk("oor rdata1", rdata1, 0);
        chk("oor wr mem_write", mem_write, 0);
        cyc();
        req1 = 0; we1 = 0;
        #1;
        chk("oorw err1", err1, 1);
        chk("oorw rvalid1", rvalid1, 0);
        chk("oorw mem", dmem[44], 32'hA5A5_002C);
        cyc();

        new_req(0);
        new_req(1);
        for (int c = 0; c < 1500; c++) begin
            rst_n = (c % 500 != 499);
            cyc();
            if (!req0 || last_g == 0) new_req(0);
            if (!req1 || last_g == 1) new_req(1);
        end
        rst_n = 1; req0 = 0; req1 = 0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
